// File: rtl/judge_display_scheduler.sv
// Judge text hold timer plus score/combo bookkeeping for the 8-digit display.
// Optional macro JUDGE_COMBO_DISPLAY_EN: o_data shows combo during SHOW, score otherwise.
module judge_display_scheduler #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int PERFECT_PTS = 10,
    parameter int NORMAL_PTS  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_hit_valid,
    input  logic [1:0]  i_hit_judge,
    output logic [1:0]  o_judge,
    output logic [15:0] o_data,
    output logic [15:0] o_combo_max
);

    localparam int TW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [16:0]   SAT_LIMIT  = 17'd9999;

    localparam logic [1:0] JUDGE_NONE    = 2'b00;
    localparam logic [1:0] JUDGE_MISS    = 2'b01;
    localparam logic [1:0] JUDGE_NORMAL  = 2'b10;
    localparam logic [1:0] JUDGE_PERFECT = 2'b11;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    judge_q, judge_d;
    logic [15:0]   score_q, score_d;
    logic [15:0]   combo_q, combo_d;
    logic [15:0]   combo_max_q, combo_max_d;
    logic [15:0]   data_q, data_d;

    logic          hit;
    logic [16:0]   pts;
    logic [16:0]   score_sum;
    logic [16:0]   combo_sum;

    assign hit = i_hit_valid && (i_hit_judge != JUDGE_NONE);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a latch;
        // blocking '=' is correct here, combo_d is read back below in the same pass.
        state_d     = state_q;
        timer_d     = timer_q;
        judge_d     = judge_q;
        score_d     = score_q;
        combo_d     = combo_q;
        combo_max_d = combo_max_q;
        data_d      = data_q;

        case (i_hit_judge)
            JUDGE_PERFECT: pts = 17'(PERFECT_PTS);
            JUDGE_NORMAL:  pts = 17'(NORMAL_PTS);
            default:       pts = '0;
        endcase
        // 17-bit sums so 9999 + points cannot wrap before the saturation compare
        score_sum = {1'b0, score_q} + pts;
        combo_sum = {1'b0, combo_q} + 17'd1;

        if (i_clear) begin
            state_d     = IDLE;
            timer_d     = '0;
            judge_d     = JUDGE_NONE;
            score_d     = '0;
            combo_d     = '0;
            combo_max_d = '0;
        end else if (hit) begin
            state_d = SHOW;
            timer_d = TIMER_LOAD;
            judge_d = i_hit_judge;
            score_d = (score_sum > SAT_LIMIT) ? SAT_LIMIT[15:0] : score_sum[15:0];
            if (i_hit_judge == JUDGE_MISS)
                combo_d = '0;
            else
                combo_d = (combo_sum > SAT_LIMIT) ? SAT_LIMIT[15:0] : combo_sum[15:0];
            combo_max_d = (combo_d > combo_max_q) ? combo_d : combo_max_q;
        end else begin
            case (state_q)
                SHOW: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                        judge_d = JUDGE_NONE;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end

`ifdef JUDGE_COMBO_DISPLAY_EN
        data_d = (state_d == SHOW) ? combo_d : score_d;
`else
        data_d = score_d;
`endif
    end

    // NOTE: sequential state uses non-blocking '<=' only; reset is synchronous
    // and overrides clear and hits because it is tested first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            judge_q     <= JUDGE_NONE;
            score_q     <= '0;
            combo_q     <= '0;
            combo_max_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            judge_q     <= judge_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            combo_max_q <= combo_max_d;
            data_q      <= data_d;
        end
    end

    assign o_judge     = judge_q;
    assign o_data      = data_q;
    assign o_combo_max = combo_max_q;

endmodule

// File: doc/judge_display_scheduler.md
JUDGE_DISPLAY_SCHEDULER -- requirements
Module: judge_display_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning judge text display time in clk cycles (minimum 2).
REQ-002 The block SHALL have parameter PERFECT_PTS, default 10, meaning score added per Perfect hit.
REQ-003 The block SHALL have parameter NORMAL_PTS, default 5, meaning score added per Normal hit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 The block SHALL have port i_clear, input, 1 bit: synchronous game-restart pulse.
REQ-007 The block SHALL have port i_hit_valid, input, 1 bit: one-cycle hit-event strobe.
REQ-008 The block SHALL have port i_hit_judge, input, 2 bits: judge code (11 Perfect, 10 Normal, 01 Miss, 00 invalid); sampled only with i_hit_valid.
REQ-009 The block SHALL have port o_judge, output, 2 bits: judge code for the 8-digit display left zone (00 = blank).
REQ-010 The block SHALL have port o_data, output, 16 bits: binary value 0..9999 for the display right zone.
REQ-011 The block SHALL have port o_combo_max, output, 16 bits: highest combo reached since the last clear or reset.

Function
REQ-012 State machine: IDLE (o_judge = 00) and SHOW (o_judge = latched judge); state, counters and outputs SHALL be registered.
REQ-013 A valid event: i_hit_valid = 1 and i_hit_judge != 00; an event with i_hit_judge = 00 SHALL be ignored completely.
REQ-014 A valid event in IDLE or SHOW: go to SHOW, latch the judge, load hold timer with HOLD_CYCLES-1; outputs reflect the event exactly one cycle after the strobe.
REQ-015 Retrigger in SHOW: a new valid event replaces the latched judge and reloads the timer; no blank cycle between.
REQ-016 In SHOW with no event, the timer decrements by 1 per cycle; at zero the block goes to IDLE next cycle, so o_judge is nonzero for exactly HOLD_CYCLES cycles after a single event.
REQ-017 Score: Perfect adds PERFECT_PTS, Normal adds NORMAL_PTS, Miss adds 0; result saturates at 9999 (never wraps).
REQ-018 Combo: Perfect/Normal increments, saturating at 9999; Miss sets combo to 0.
REQ-019 o_combo_max is updated in the same cycle as combo to max(o_combo_max, new combo).
REQ-020 i_clear = 1: score, combo, o_combo_max cleared to 0, state to IDLE, timer to 0, next cycle; i_clear takes priority over a simultaneous hit.
REQ-021 o_data = score, except as stated in REQ-025.
REQ-022 Internal arithmetic SHALL be at least 17 bits wide before saturation so that 9999 + PERFECT_PTS cannot overflow.

Reset
REQ-023 With rst = 0 at a rising edge: state IDLE, timer 0, score 0, combo 0, o_judge 00, o_data 0, o_combo_max 0; rst has priority over i_clear and hits.
REQ-024 Reset asserted mid-SHOW SHALL blank o_judge on the next cycle with no residual timer effect after release.

Configuration
REQ-025 Macro JUDGE_COMBO_DISPLAY_EN defined: o_data shows combo while in SHOW and score in IDLE; not defined: o_data always shows score, and combo logic is still kept for o_combo_max.

Verification
REQ-026 Reset, then 3 Perfect strobes 10 cycles apart -> o_data 30, o_judge 11, combo 3, o_combo_max 3.
REQ-027 HOLD_CYCLES=8, one Normal strobe at cycle 0 -> o_judge 10 during cycles 1..8, 00 from cycle 9; o_data 5.
REQ-028 HOLD_CYCLES=8, Perfect at 0, Miss at 5 -> o_judge 11 for cycles 1..5, 01 for cycles 6..13, 00 at 14; combo 0, o_combo_max 1.
REQ-029 Preload score 9995, Perfect strobe -> o_data 9999; a further Normal -> still 9999.
REQ-030 i_clear and Perfect strobe same cycle after score 50 -> score 0, o_judge 00, o_combo_max 0; i_hit_judge=00 strobe -> no change.
REQ-031 JUDGE_COMBO_DISPLAY_EN defined, 4 Normals then timeout -> o_data 4 during SHOW, 20 after return to IDLE.
